// File: rtl/priority_decoder.sv
// priority_decoder: turns the 4-bit index from a 16-line priority encoder into a
// registered one-hot grant. The grant is held until ack, until a hold timeout,
// or until En drops. Every grant is followed by a one-cycle RELEASE gap.
//
//   state   | meaning
//   --------+----------------------------------------------------------------
//   IDLE    | no grant; waiting for En=1 and VALID=1
//   GRANT   | g one-hot at grant_idx; waiting for ack, timeout or abort
//   RELEASE | one-cycle gap with g=0; requests and ack are ignored
module priority_decoder #(
    parameter int unsigned TIMEOUT = 16   // legal range 1..31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        En,
    input  logic [3:0]  y,
    input  logic        VALID,
    input  logic        ack,
    output logic [15:0] g,
    output logic [3:0]  grant_idx,
    output logic        busy,
    output logic        timeout,
    output logic [7:0]  grant_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Hold counter value on the final cycle of GRANT before a forced release.
    localparam logic [4:0] HOLD_LAST = 5'(TIMEOUT - 1);

    state_t     state;
    logic [4:0] hold_cnt;

    // Grant FSM. Every output is a register updated together with the state.
    // Inside GRANT the priority is: En low (abort), then ack, then timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            g         <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            grant_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            // timeout is a single-cycle pulse; it is only raised on a forced release
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (En && VALID) begin
                        state     <= GRANT;
                        busy      <= 1'b1;
                        g         <= 16'h0001 << y;
                        grant_idx <= y;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (!En) begin
                        // Abort: ack is ignored and nothing is counted.
                        state <= RELEASE;
                        g     <= '0;
                    end else if (ack) begin
                        // ack also wins on the cycle the hold limit is reached.
                        state <= RELEASE;
                        g     <= '0;
                        if (grant_cnt != 8'hFF) begin
                            grant_cnt <= grant_cnt + 8'd1;
                        end
                    end else if (hold_cnt == HOLD_LAST) begin
                        state   <= RELEASE;
                        g       <= '0;
                        timeout <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 5'd1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    g     <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/priority_decoder.md
PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
REQ-001 Parameter: TIMEOUT, default 16, number of GRANT-state cycles without ack before forced release; legal range 1..31.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: En  input  1  block enable; low blocks new grants and aborts an active grant.
REQ-005 Port: y  input  4  encoded request index from the 16-line priority encoder.
REQ-006 Port: VALID  input  1  high when y carries a live request.
REQ-007 Port: ack  input  1  requester acknowledge; ends the current grant.
REQ-008 Port: g  output  16  registered one-hot grant lines; bit n is grant to line n.
REQ-009 Port: grant_idx  output  4  registered copy of the captured index.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.
REQ-011 Port: timeout  output  1  one-cycle pulse on forced release.
REQ-012 Port: grant_cnt  output  8  saturating count of grants ended by ack.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, GRANT, RELEASE.
REQ-014 IDLE: on an edge with En=1 and VALID=1, y SHALL be captured into grant_idx, g SHALL become 1<<y, the hold counter SHALL clear to 0, and the state SHALL go to GRANT; g is visible one cycle after the request is sampled.
REQ-015 IDLE with En=0 or VALID=0: state, g, and grant_idx SHALL hold; g SHALL be all-zero.
REQ-016 GRANT: g SHALL stay exactly one-hot at bit grant_idx; changes on y/VALID SHALL be ignored.
REQ-017 GRANT with ack=1 (and En=1): next edge g SHALL be 0, the state SHALL go to RELEASE, and grant_cnt SHALL increment, saturating at 255.
REQ-018 GRANT without ack: the hold counter SHALL increment each cycle; on the edge where it equals TIMEOUT-1, g SHALL clear, the state SHALL go to RELEASE, and timeout SHALL be 1 for exactly the following cycle.
REQ-019 Simultaneous ack and timeout condition: ack SHALL win, timeout SHALL stay 0, and grant_cnt SHALL increment.
REQ-020 GRANT with En=0: abort; g SHALL clear and the state SHALL go to RELEASE, with no timeout pulse, no grant_cnt change, and ack ignored.
REQ-021 RELEASE SHALL last exactly one cycle with g=0 and busy=1, then go to IDLE; requests and ack during RELEASE SHALL be ignored (not queued).
REQ-022 A request held continuously SHALL therefore be re-granted no sooner than 2 cycles after g falls.
REQ-023 ack in IDLE or RELEASE SHALL have no effect.
REQ-024 g SHALL never have more than one bit set in any cycle.
REQ-025 grant_idx SHALL hold its last captured value until the next capture.

Reset
REQ-026 With rst=1 at an edge, the state SHALL be IDLE; g, grant_idx, grant_cnt, and the hold counter SHALL be 0; busy=0 and timeout=0; this SHALL apply from any state, including mid-GRANT.
REQ-027 rst SHALL take priority over all other inputs in the same cycle.
REQ-028 The first grant after reset release SHALL require a fresh En=1/VALID=1 sample.

Verification
REQ-029 Basic grant: En=1, VALID=1, y=4'd5, then ack=1 on the 3rd GRANT cycle -> g=16'h0020 for 3 cycles, then 0, busy low 2 cycles after ack, grant_cnt=1.
REQ-030 Timeout: TIMEOUT=4, y=4'd15, no ack -> g=16'h8000 for 4 cycles, timeout pulses once, grant_cnt unchanged.
REQ-031 Ack on the last timeout cycle: TIMEOUT=4, ack in GRANT cycle 4 -> timeout stays 0, grant_cnt increments.
REQ-032 Abort: y=4'd0 granted, En dropped in GRANT cycle 2 -> g=0 next cycle, timeout=0, grant_cnt unchanged; an En=0 request in IDLE yields no grant.
REQ-033 Sweep y=0..15 back-to-back with an immediate ack each -> g one-hot 16'h0001..16'h8000 in order, each grant separated by at least a 1-cycle gap, grant_cnt=16.
REQ-034 Reset mid-GRANT (y=4'd7) -> next cycle g=0, busy=0, grant_idx=0, grant_cnt=0; 256+ acked grants -> grant_cnt saturates at 255.
